crossing_scheduler: RTL and testbench
=====================================

CROSSING_SCHEDULER -- requirements
Module: crossing_scheduler

Interface
REQ-001 Parameter T_GREEN, default 10, minimum main-green dwell in ticks.
REQ-002 Parameter T_YELLOW, default 3, yellow dwell in ticks (either road).
REQ-003 Parameter T_ALLRED, default 2, all-red clearance dwell in ticks.
REQ-004 Parameter T_SIDE, default 8, side-green dwell in ticks.
REQ-005 Parameter T_WALK, default 6, pedestrian walk dwell in ticks.
REQ-006 Parameter T_SIDE_MAX, default 16, side-green ceiling in ticks, used only when EXTEND_GREEN_EN is defined.
REQ-007 Port clock  input  1  sole clock, all logic on posedge.
REQ-008 Port reset  input  1  synchronous reset, active-high.
REQ-009 Port tick  input  1  one-cycle timebase enable, 1 Hz nominal.
REQ-010 Port ped_req  input  1  debounced pedestrian button level.
REQ-011 Port car_req  input  1  debounced side-street car sensor level.
REQ-012 Port main_light  output  3  {red,yellow,green}, one-hot.
REQ-013 Port side_light  output  3  {red,yellow,green}, one-hot.
REQ-014 Port walk  output  1  pedestrian walk lamp.
REQ-015 Port ped_pending  output  1  latched pedestrian request not yet served.
REQ-016 Port phase  output  3  current state encoding, for debug.

Function
REQ-017 The FSM SHALL have states MAIN_GRN=0, MAIN_YEL=1, ALLRED_A=2, SIDE_GRN=3, SIDE_YEL=4, ALLRED_B=5, WALK=6; code 7 SHALL recover to MAIN_GRN on the next cycle.
REQ-018 An 8-bit dwell timer SHALL increment only on cycles with tick=1, and SHALL clear to 0 on every state transition.
REQ-019 A dwell of N expires on the clock edge where tick=1 and timer==N-1; the transition takes effect on that edge.
REQ-020 Outputs SHALL be Moore-decoded from the state register: MAIN_GRN main=G side=R; MAIN_YEL main=Y side=R; SIDE_GRN main=R side=G; SIDE_YEL main=R side=Y; ALLRED_A, ALLRED_B, WALK both R; walk=1 only in WALK.
REQ-021 ped_pending SHALL set on a ped_req rising edge, detected against a 1-cycle registered copy, and SHALL clear on entry to WALK; a rising edge while in WALK SHALL NOT set it.
REQ-022 MAIN_GRN SHALL hold while the dwell is unexpired or no request exists (ped_pending=0 and car_req=0); on expiry with a request -> MAIN_YEL.
REQ-023 MAIN_YEL -> ALLRED_A after T_YELLOW.
REQ-024 ALLRED_A -> WALK or SIDE_GRN after T_ALLRED, per the arbitration in REQ-025.
REQ-025 Arbitration SHALL use a last_served flag (0=ped, 1=car): if only one request is active, serve it; if both, serve the one not last served; if neither is active (request withdrawn), go to ALLRED_B.
REQ-026 The service decision SHALL be sampled on the ALLRED_A expiry edge, and last_served SHALL update on the same edge.
REQ-027 SIDE_GRN -> SIDE_YEL after T_SIDE; SIDE_YEL -> ALLRED_B after T_YELLOW; WALK -> ALLRED_B after T_WALK; ALLRED_B -> MAIN_GRN after T_ALLRED.
REQ-028 Main and side lights SHALL never show non-red simultaneously, and walk=1 SHALL imply both red.

Reset
REQ-029 On reset=1 at a clock edge: state=MAIN_GRN, timer=0, ped_pending=0, last_served=1, edge register=ped_req; outputs main=G, side=R, walk=0, phase=0 on the following cycle.
REQ-030 Reset mid-phase SHALL abandon the phase immediately; reset SHALL take priority over tick and requests on the same edge.

Configuration
REQ-031 With macro EXTEND_GREEN_EN defined, SIDE_GRN SHALL stay past T_SIDE while car_req=1, exiting when car_req=0 on a tick edge after T_SIDE, or at T_SIDE_MAX regardless.
REQ-032 Without EXTEND_GREEN_EN, SIDE_GRN SHALL last exactly T_SIDE ticks, T_SIDE_MAX SHALL be unused, and no extension logic SHALL be built.

Verification
REQ-033 Reset, no requests, 50 ticks -> phase stays 0, main_light=001, side_light=100.
REQ-034 ped_req pulse at tick 2 -> ped_pending=1 next cycle; MAIN_YEL at tick 10, ALLRED_A at 13, WALK at 15 with walk=1 and ped_pending=0, ALLRED_B at 21, MAIN_GRN at 23.
REQ-035 car_req held high from reset -> SIDE_GRN entered at tick 15, SIDE_YEL at tick 23; repeat ped_req plus car_req both pending at ALLRED_A expiry twice -> served ped then car (alternation).
REQ-036 car_req asserted then dropped during MAIN_YEL, no ped -> ALLRED_A -> ALLRED_B -> MAIN_GRN, side never green.
REQ-037 Reset asserted mid-WALK -> next cycle phase=0, walk=0, ped_pending=0; timer restarts from 0.
REQ-038 With EXTEND_GREEN_EN, car_req held high through SIDE_GRN -> exit at T_SIDE_MAX=16 ticks; car_req dropped at tick 10 -> exit at the tick-10 edge.

Source files
------------

// File: rtl/crossing_scheduler.sv
// Traffic/pedestrian crossing sequencer with tick-based dwell timing and ped/car arbitration.
// Optional side-green extension while car_req is held: define EXTEND_GREEN_EN.
module crossing_scheduler #(
    parameter int unsigned T_GREEN    = 10,
    parameter int unsigned T_YELLOW   = 3,
    parameter int unsigned T_ALLRED   = 2,
    parameter int unsigned T_SIDE     = 8,
    parameter int unsigned T_WALK     = 6,
    parameter int unsigned T_SIDE_MAX = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       car_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        MAIN_GRN = 3'd0,
        MAIN_YEL = 3'd1,
        ALLRED_A = 3'd2,
        SIDE_GRN = 3'd3,
        SIDE_YEL = 3'd4,
        ALLRED_B = 3'd5,
        WALK     = 3'd6
    } state_e;

    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       ped_pend_q, ped_pend_d;
    logic       last_q, last_d;
    logic       ped_prev_q;
    logic       ped_rise;
    logic       exp_green, exp_yellow, exp_allred, exp_side, exp_walk;

    assign ped_rise   = ped_req & ~ped_prev_q;
    // Main green is a minimum dwell: once reached, any later tick with a request leaves.
    assign exp_green  = tick && (timer_q >= 8'(T_GREEN - 1));
    assign exp_yellow = tick && (timer_q == 8'(T_YELLOW - 1));
    assign exp_allred = tick && (timer_q == 8'(T_ALLRED - 1));
    assign exp_walk   = tick && (timer_q == 8'(T_WALK - 1));
`ifdef EXTEND_GREEN_EN
    assign exp_side   = tick && (((timer_q >= 8'(T_SIDE - 1)) && !car_req) ||
                                 (timer_q == 8'(T_SIDE_MAX - 1)));
`else
    assign exp_side   = tick && (timer_q == 8'(T_SIDE - 1));
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            MAIN_GRN: if (exp_green && (ped_pend_q || car_req)) state_d = MAIN_YEL;
            MAIN_YEL: if (exp_yellow) state_d = ALLRED_A;
            ALLRED_A: begin
                if (exp_allred) begin
                    // Both pending: serve whichever was not served last (last_q=1 means car).
                    if (ped_pend_q && (!car_req || last_q)) begin
                        state_d = WALK;
                        last_d  = 1'b0;
                    end else if (car_req) begin
                        state_d = SIDE_GRN;
                        last_d  = 1'b1;
                    end else begin
                        state_d = ALLRED_B;
                    end
                end
            end
            SIDE_GRN: if (exp_side) state_d = SIDE_YEL;
            SIDE_YEL: if (exp_yellow) state_d = ALLRED_B;
            WALK:     if (exp_walk) state_d = ALLRED_B;
            ALLRED_B: if (exp_allred) state_d = MAIN_GRN;
            default:  state_d = MAIN_GRN;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (tick && (timer_q != '1)) begin
            timer_d = timer_q + 8'd1;
        end
    end

    always_comb begin
        ped_pend_d = ped_pend_q;
        if ((state_d == WALK) && (state_q != WALK)) begin
            ped_pend_d = 1'b0;
        end else if (ped_rise && (state_q != WALK)) begin
            ped_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= MAIN_GRN;
            timer_q    <= '0;
            ped_pend_q <= 1'b0;
            last_q     <= 1'b1;
            ped_prev_q <= ped_req;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ped_pend_q <= ped_pend_d;
            last_q     <= last_d;
            ped_prev_q <= ped_req;
        end
    end

    always_comb begin
        main_light = LIGHT_R;
        side_light = LIGHT_R;
        walk       = 1'b0;
        case (state_q)
            MAIN_GRN: main_light = LIGHT_G;
            MAIN_YEL: main_light = LIGHT_Y;
            SIDE_GRN: side_light = LIGHT_G;
            SIDE_YEL: side_light = LIGHT_Y;
            WALK:     walk       = 1'b1;
            default:  ;
        endcase
    end

    assign ped_pending = ped_pend_q;
    assign phase       = state_q;

endmodule

// File: tb/tb_crossing_scheduler.sv
// Scoreboard bench for crossing_scheduler: expected phase transitions (tick number, phase) are queued
// up front and popped as the DUT changes phase. Build with +define+EXTEND_GREEN_EN to cover extension.
module tb_crossing_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       car_req = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

    typedef struct {
        int         t;
        logic [2:0] ph;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         checks = 0;
    int         errors = 0;
    int         tcount = 0;
    logic [2:0] last_ph;

`ifdef EXTEND_GREEN_EN
    localparam int SIDE_HELD = 16;
`else
    localparam int SIDE_HELD = 8;
`endif

    crossing_scheduler #(
        .T_GREEN   (10),
        .T_YELLOW  (3),
        .T_ALLRED  (2),
        .T_SIDE    (8),
        .T_WALK    (6),
        .T_SIDE_MAX(16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .ped_req    (ped_req),
        .car_req    (car_req),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .ped_pending(ped_pending),
        .phase      (phase)
    );

    always #5 clock = ~clock;

    // All stimulus changes at negedge; outputs sampled at negedge.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tcount  = 0;
        last_ph = 3'd0;
        exp_q.delete();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        tcount++;
    endtask

    task automatic pulse_ped();
        ped_req = 1'b1;
        @(negedge clock);
        ped_req = 1'b0;
    endtask

    task automatic push_exp(input int t, input logic [2:0] p);
        exp_q.push_back('{t: t, ph: p});
    endtask

    task automatic test_reset();
        pulse_ped();
        do_reset();
        checks++;
        if (phase !== 3'd0 || main_light !== 3'b001 || side_light !== 3'b100 ||
            walk !== 1'b0 || ped_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: phase=%0d main=%b side=%b walk=%b pend=%b, want 0 001 100 0 0",
                     phase, main_light, side_light, walk, ped_pending);
        end
        for (int i = 0; i < 50; i++) begin
            do_tick();
            checks++;
            if (phase !== 3'd0) begin
                errors++;
                $display("FAIL idle_phase: tick %0d phase=%0d, want 0", tcount, phase);
            end
        end
        checks++;
        if (main_light !== 3'b001 || side_light !== 3'b100) begin
            errors++;
            $display("FAIL idle_lights: main=%b side=%b, want 001 100", main_light, side_light);
        end
    endtask

    task automatic test_ped();
        do_reset();
        push_exp(10, 3'd1); push_exp(13, 3'd2); push_exp(15, 3'd6);
        push_exp(21, 3'd5); push_exp(23, 3'd0);
        for (int i = 0; i < 28; i++) begin
            do_tick();
            if (tcount == 2) begin
                pulse_ped();
                checks++;
                if (ped_pending !== 1'b1) begin
                    errors++;
                    $display("FAIL ped_latch: ped_pending=%b, want 1", ped_pending);
                end
            end
            if (phase !== last_ph) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ped_unexpected: tick %0d phase=%0d, want no transition", tcount, phase);
                end else begin
                    e = exp_q.pop_front();
                    if (e.t != tcount || e.ph !== phase) begin
                        errors++;
                        $display("FAIL ped_seq: tick %0d phase=%0d, want tick %0d phase=%0d",
                                 tcount, phase, e.t, e.ph);
                    end
                end
                if (phase == 3'd6) begin
                    checks++;
                    if (walk !== 1'b1 || ped_pending !== 1'b0 || main_light !== 3'b100 ||
                        side_light !== 3'b100) begin
                        errors++;
                        $display("FAIL walk_entry: walk=%b pend=%b main=%b side=%b, want 1 0 100 100",
                                 walk, ped_pending, main_light, side_light);
                    end
                end
                last_ph = phase;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ped_missing: %0d transitions outstanding, want 0", exp_q.size());
        end
    endtask

    task automatic test_car_alternation();
        int t;
        int p2;
        int last_t;
        car_req = 1'b1;
        do_reset();
        t = 0;
        t += 10;        push_exp(t, 3'd1);
        t += 3;         push_exp(t, 3'd2);
        t += 2;         push_exp(t, 3'd3);
        t += SIDE_HELD; push_exp(t, 3'd4);
        t += 3;         push_exp(t, 3'd5);
        t += 2;         push_exp(t, 3'd0);
        t += 10;        push_exp(t, 3'd1);
        t += 3;         push_exp(t, 3'd2);
        t += 2;         push_exp(t, 3'd6);
        t += 6;         push_exp(t, 3'd5);
        t += 2;         push_exp(t, 3'd0);
        p2 = t + 1;
        t += 10;        push_exp(t, 3'd1);
        t += 3;         push_exp(t, 3'd2);
        t += 2;         push_exp(t, 3'd3);
        t += SIDE_HELD; push_exp(t, 3'd4);
        t += 3;         push_exp(t, 3'd5);
        t += 2;         push_exp(t, 3'd0);
        last_t = t;
        for (int i = 0; i < last_t + 2; i++) begin
            do_tick();
            if (tcount == 30 || tcount == p2) pulse_ped();
            checks++;
            if ((main_light !== 3'b100 && side_light !== 3'b100) ||
                (walk === 1'b1 && (main_light !== 3'b100 || side_light !== 3'b100))) begin
                errors++;
                $display("FAIL car_conflict: tick %0d main=%b side=%b walk=%b, want no conflict",
                         tcount, main_light, side_light, walk);
            end
            if (phase !== last_ph) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL car_unexpected: tick %0d phase=%0d, want no transition", tcount, phase);
                end else begin
                    e = exp_q.pop_front();
                    if (e.t != tcount || e.ph !== phase) begin
                        errors++;
                        $display("FAIL car_seq: tick %0d phase=%0d, want tick %0d phase=%0d",
                                 tcount, phase, e.t, e.ph);
                    end
                end
                if (phase == 3'd3) begin
                    checks++;
                    if (side_light !== 3'b001 || main_light !== 3'b100) begin
                        errors++;
                        $display("FAIL side_lights: main=%b side=%b, want 100 001", main_light, side_light);
                    end
                end
                last_ph = phase;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL car_missing: %0d transitions outstanding, want 0", exp_q.size());
        end
        car_req = 1'b0;
    endtask

    task automatic test_withdraw();
        logic side_seen_green;
        side_seen_green = 1'b0;
        car_req = 1'b0;
        do_reset();
        push_exp(10, 3'd1); push_exp(13, 3'd2); push_exp(15, 3'd5); push_exp(17, 3'd0);
        for (int i = 0; i < 22; i++) begin
            do_tick();
            if (tcount == 5)  car_req = 1'b1;
            if (tcount == 11) car_req = 1'b0;
            if (side_light === 3'b001) side_seen_green = 1'b1;
            if (phase !== last_ph) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wd_unexpected: tick %0d phase=%0d, want no transition", tcount, phase);
                end else begin
                    e = exp_q.pop_front();
                    if (e.t != tcount || e.ph !== phase) begin
                        errors++;
                        $display("FAIL wd_seq: tick %0d phase=%0d, want tick %0d phase=%0d",
                                 tcount, phase, e.t, e.ph);
                    end
                end
                last_ph = phase;
            end
        end
        checks++;
        if (side_seen_green !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wd_end: side_green_seen=%b outstanding=%0d, want 0 0",
                     side_seen_green, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_walk();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            do_tick();
            if (tcount == 1) pulse_ped();
        end
        checks++;
        if (phase !== 3'd6 || walk !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_walk: phase=%0d walk=%b, want 6 1", phase, walk);
        end
        // Reset and tick land on the same edge; reset must win.
        reset = 1'b1;
        tick  = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tick  = 1'b0;
        tcount  = 0;
        last_ph = 3'd0;
        exp_q.delete();
        checks++;
        if (phase !== 3'd0 || walk !== 1'b0 || ped_pending !== 1'b0 || main_light !== 3'b001) begin
            errors++;
            $display("FAIL reset_walk: phase=%0d walk=%b pend=%b main=%b, want 0 0 0 001",
                     phase, walk, ped_pending, main_light);
        end
        push_exp(10, 3'd1);
        for (int i = 0; i < 11; i++) begin
            do_tick();
            if (tcount == 1) pulse_ped();
            if (phase !== last_ph) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rw_unexpected: tick %0d phase=%0d, want no transition", tcount, phase);
                end else begin
                    e = exp_q.pop_front();
                    if (e.t != tcount || e.ph !== phase) begin
                        errors++;
                        $display("FAIL rw_seq: tick %0d phase=%0d, want tick %0d phase=%0d",
                                 tcount, phase, e.t, e.ph);
                    end
                end
                last_ph = phase;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rw_missing: %0d transitions outstanding, want 0", exp_q.size());
        end
    endtask

`ifdef EXTEND_GREEN_EN
    task automatic test_extend();
        car_req = 1'b1;
        do_reset();
        push_exp(10, 3'd1); push_exp(13, 3'd2); push_exp(15, 3'd3); push_exp(31, 3'd4);
        push_exp(34, 3'd5); push_exp(36, 3'd0); push_exp(46, 3'd1); push_exp(49, 3'd2);
        push_exp(51, 3'd3); push_exp(61, 3'd4); push_exp(64, 3'd5); push_exp(66, 3'd0);
        for (int i = 0; i < 70; i++) begin
            do_tick();
            if (tcount == 60) car_req = 1'b0;
            if (phase !== last_ph) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ext_unexpected: tick %0d phase=%0d, want no transition", tcount, phase);
                end else begin
                    e = exp_q.pop_front();
                    if (e.t != tcount || e.ph !== phase) begin
                        errors++;
                        $display("FAIL ext_seq: tick %0d phase=%0d, want tick %0d phase=%0d",
                                 tcount, phase, e.t, e.ph);
                    end
                end
                last_ph = phase;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ext_missing: %0d transitions outstanding, want 0", exp_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ped();
        test_car_alternation();
        test_withdraw();
        test_reset_mid_walk();
`ifdef EXTEND_GREEN_EN
        test_extend();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
